// File: rtl/carp_pkg.sv
// Shared types for the CARP RV32I core: ALU control codes, major opcodes
// and immediate-format selects used by decode and its helpers.
package carp_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SLL    = 4'b0001,
        ALU_SLT    = 4'b0010,
        ALU_SLTU   = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SRL    = 4'b0101,
        ALU_OR     = 4'b0110,
        ALU_AND    = 4'b0111,
        ALU_SUB    = 4'b1000,
        ALU_COPY_A = 4'b1001,
        ALU_SRA    = 4'b1101
    } alu_ctrl_e;

    typedef logic [6:0] opcode_e;

    localparam opcode_e OPC_OP     = 7'b0110011;
    localparam opcode_e OPC_OP_IMM = 7'b0010011;
    localparam opcode_e OPC_LUI    = 7'b0110111;
    localparam opcode_e OPC_AUIPC  = 7'b0010111;
    localparam opcode_e OPC_LOAD   = 7'b0000011;
    localparam opcode_e OPC_STORE  = 7'b0100011;
    localparam opcode_e OPC_BRANCH = 7'b1100011;
    localparam opcode_e OPC_JAL    = 7'b1101111;
    localparam opcode_e OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the RV32I I/S/B/U/J
// immediate from an instruction word. Purely combinational.
module imm_gen
    import carp_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   sel,
    output logic [31:0] imm
);

    // Reassemble the scattered immediate fields for the selected format
    always_comb begin
        imm = 32'd0;
        case (sel)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'd0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// CARP RV32I decode stage: decodes the fetched instruction into ALU control,
// bypassed operands and immediate, and holds the result in the ID/EX register
// under a valid/ready handshake.
module decode_stage
    import carp_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_VALID,
    output logic        IF_READY,
    input  logic [31:0] IF_INSTR,
    input  logic [31:0] IF_PC,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    input  logic        WB_WE,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA,
    input  logic        FLUSH,
    output logic        EX_VALID,
    input  logic        EX_READY,
    output logic [3:0]  EX_ALU_CTRL,
    output logic [31:0] EX_SRC_A,
    output logic [31:0] EX_SRC_B,
    output logic [31:0] EX_RS2_VAL,
    output logic [4:0]  EX_RD,
    output logic        EX_REG_WE,
    output logic [31:0] EX_PC,
    output logic        EX_BR,
    output logic [2:0]  EX_BR_F3,
    output logic        EX_ILLEGAL
);

    // ---- stage p0: combinational decode of IF_INSTR ----
    opcode_e     opcode_p0;
    logic [2:0]  funct3_p0;
    logic [6:0]  funct7_p0;
    logic [4:0]  rd_p0;
    logic [31:0] rs1_val_p0;
    logic [31:0] rs2_val_p0;
    imm_type_e   imm_sel_p0;
    logic [31:0] imm_p0;
    logic [3:0]  alu_p0;
    logic [31:0] src_a_p0;
    logic [31:0] src_b_p0;
    logic        reg_we_p0;
    logic        br_p0;
    logic        illegal_p0;
    logic        accept_p0;
    logic        transfer_p0;

    assign opcode_p0 = IF_INSTR[6:0];
    assign rd_p0     = IF_INSTR[11:7];
    assign funct3_p0 = IF_INSTR[14:12];
    assign funct7_p0 = IF_INSTR[31:25];
    assign RS1_ADDR  = IF_INSTR[19:15];
    assign RS2_ADDR  = IF_INSTR[24:20];

    assign IF_READY    = !EX_VALID || EX_READY;
    assign accept_p0   = IF_VALID && IF_READY;
    assign transfer_p0 = EX_VALID && EX_READY;

    // Immediate format depends only on the opcode, so it is selected outside
    // the decode block to keep imm_gen out of that block's dependency loop.
    assign imm_sel_p0 = (opcode_p0 == OPC_STORE)  ? IMM_S :
                        (opcode_p0 == OPC_BRANCH) ? IMM_B :
                        (opcode_p0 == OPC_JAL)    ? IMM_J :
                        (opcode_p0 == OPC_LUI || opcode_p0 == OPC_AUIPC) ? IMM_U :
                        IMM_I;

    imm_gen u_imm_gen (
        .instr (IF_INSTR),
        .sel   (imm_sel_p0),
        .imm   (imm_p0)
    );

    // x0 reads as zero; otherwise a matching writeback overrides the regfile
    assign rs1_val_p0 = (RS1_ADDR == 5'd0) ? 32'd0 :
                        (WB_WE && WB_RD == RS1_ADDR) ? WB_DATA : RS1_DATA;
    assign rs2_val_p0 = (RS2_ADDR == 5'd0) ? 32'd0 :
                        (WB_WE && WB_RD == RS2_ADDR) ? WB_DATA : RS2_DATA;

    // Decode opcode/funct fields into ALU control, operand selection and flags
    always_comb begin
        alu_p0     = ALU_ADD;
        src_a_p0   = rs1_val_p0;
        src_b_p0   = rs2_val_p0;
        reg_we_p0  = 1'b0;
        br_p0      = 1'b0;
        illegal_p0 = 1'b0;
        case (opcode_p0)
            OPC_OP: begin
                reg_we_p0 = 1'b1;
                if (funct7_p0 == 7'b0000000 ||
                    (funct7_p0 == 7'b0100000 && (funct3_p0 == 3'b000 || funct3_p0 == 3'b101)))
                    alu_p0 = {IF_INSTR[30], funct3_p0};
                else
                    illegal_p0 = 1'b1;
            end
            OPC_OP_IMM: begin
                reg_we_p0 = 1'b1;
                alu_p0    = {1'b0, funct3_p0};
                src_b_p0  = imm_p0;
                // Shift-immediates present the bare shift amount, not the
                // sign-extended field that also carries the funct7 bits.
                if (funct3_p0 == 3'b001) begin
                    src_b_p0 = {27'd0, IF_INSTR[24:20]};
                    if (funct7_p0 != 7'b0000000)
                        illegal_p0 = 1'b1;
                end else if (funct3_p0 == 3'b101) begin
                    src_b_p0 = {27'd0, IF_INSTR[24:20]};
                    if (funct7_p0 == 7'b0100000)
                        alu_p0 = ALU_SRA;
                    else if (funct7_p0 != 7'b0000000)
                        illegal_p0 = 1'b1;
                end
            end
            OPC_LUI: begin
                reg_we_p0 = 1'b1;
                alu_p0    = ALU_COPY_A;
                src_a_p0  = imm_p0;
                src_b_p0  = 32'd0;
            end
            OPC_AUIPC: begin
                reg_we_p0 = 1'b1;
                src_a_p0  = IF_PC;
                src_b_p0  = imm_p0;
            end
            OPC_LOAD: begin
                reg_we_p0 = 1'b1;
                src_b_p0  = imm_p0;
            end
            OPC_STORE: begin
                src_b_p0 = imm_p0;
            end
            OPC_JAL, OPC_JALR: begin
                reg_we_p0 = 1'b1;
                src_a_p0  = IF_PC;
                src_b_p0  = 32'd4;
            end
            OPC_BRANCH: begin
                br_p0 = 1'b1;
                case (funct3_p0)
                    3'b000, 3'b001: alu_p0 = ALU_SUB;
                    3'b100, 3'b101: alu_p0 = ALU_SLT;
                    3'b110, 3'b111: alu_p0 = ALU_SLTU;
                    default:        illegal_p0 = 1'b1;
                endcase
            end
            default: illegal_p0 = 1'b1;
        endcase
        if (illegal_p0) begin
            alu_p0    = ALU_ADD;
            reg_we_p0 = 1'b0;
            br_p0     = 1'b0;
        end
        if (rd_p0 == 5'd0)
            reg_we_p0 = 1'b0;
    end

    // ---- stage p1: ID/EX pipeline register ----
    // ID/EX register: reset clears everything, flush drops valid, accept loads
    always_ff @(posedge CLK) begin
        if (RST) begin
            EX_VALID    <= 1'b0;
            EX_ALU_CTRL <= 4'd0;
            EX_SRC_A    <= 32'd0;
            EX_SRC_B    <= 32'd0;
            EX_RS2_VAL  <= 32'd0;
            EX_RD       <= 5'd0;
            EX_REG_WE   <= 1'b0;
            EX_PC       <= 32'd0;
            EX_BR       <= 1'b0;
            EX_BR_F3    <= 3'd0;
            EX_ILLEGAL  <= 1'b0;
        end else if (FLUSH) begin
            EX_VALID <= 1'b0;
        end else if (accept_p0) begin
            EX_VALID    <= 1'b1;
            EX_ALU_CTRL <= alu_p0;
            EX_SRC_A    <= src_a_p0;
            EX_SRC_B    <= src_b_p0;
            EX_RS2_VAL  <= rs2_val_p0;
            EX_RD       <= rd_p0;
            EX_REG_WE   <= reg_we_p0;
            EX_PC       <= IF_PC;
            EX_BR       <= br_p0;
            EX_BR_F3    <= funct3_p0;
            EX_ILLEGAL  <= illegal_p0;
        end else if (transfer_p0) begin
            EX_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic        CLK;
    logic        RST;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        WB_WE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        FLUSH;
    logic        EX_VALID;
    logic        EX_READY;
    logic [3:0]  EX_ALU_CTRL;
    logic [31:0] EX_SRC_A;
    logic [31:0] EX_SRC_B;
    logic [31:0] EX_RS2_VAL;
    logic [4:0]  EX_RD;
    logic        EX_REG_WE;
    logic [31:0] EX_PC;
    logic        EX_BR;
    logic [2:0]  EX_BR_F3;
    logic        EX_ILLEGAL;

    int errors = 0;
    int checks = 0;

    decode_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .IF_VALID    (IF_VALID),
        .IF_READY    (IF_READY),
        .IF_INSTR    (IF_INSTR),
        .IF_PC       (IF_PC),
        .RS1_ADDR    (RS1_ADDR),
        .RS2_ADDR    (RS2_ADDR),
        .RS1_DATA    (RS1_DATA),
        .RS2_DATA    (RS2_DATA),
        .WB_WE       (WB_WE),
        .WB_RD       (WB_RD),
        .WB_DATA     (WB_DATA),
        .FLUSH       (FLUSH),
        .EX_VALID    (EX_VALID),
        .EX_READY    (EX_READY),
        .EX_ALU_CTRL (EX_ALU_CTRL),
        .EX_SRC_A    (EX_SRC_A),
        .EX_SRC_B    (EX_SRC_B),
        .EX_RS2_VAL  (EX_RS2_VAL),
        .EX_RD       (EX_RD),
        .EX_REG_WE   (EX_REG_WE),
        .EX_PC       (EX_PC),
        .EX_BR       (EX_BR),
        .EX_BR_F3    (EX_BR_F3),
        .EX_ILLEGAL  (EX_ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction with regfile data, valid and ready raised
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        IF_INSTR = instr;
        IF_PC    = pc;
        RS1_DATA = d1;
        RS2_DATA = d2;
        IF_VALID = 1'b1;
        EX_READY = 1'b1;
    endtask

    initial begin
        RST = 1'b1; IF_VALID = 1'b0; IF_INSTR = 32'd0; IF_PC = 32'd0;
        RS1_DATA = 32'd0; RS2_DATA = 32'd0; WB_WE = 1'b0; WB_RD = 5'd0;
        WB_DATA = 32'd0; FLUSH = 1'b0; EX_READY = 1'b0;
        step();
        step();
        RST = 1'b0;
        chk("rst_valid", {31'd0, EX_VALID}, 32'd0);
        chk("rst_alu", {28'd0, EX_ALU_CTRL}, 32'd0);
        chk("rst_srca", EX_SRC_A, 32'd0);
        chk("rst_ifready", {31'd0, IF_READY}, 32'd1);

        // ADD x3,x1,x2
        issue(32'h002081B3, 32'h0000_0040, 32'd5, 32'd7);
        #1;
        chk("add_rs1addr", {27'd0, RS1_ADDR}, 32'd1);
        chk("add_rs2addr", {27'd0, RS2_ADDR}, 32'd2);
        step();
        chk("add_valid", {31'd0, EX_VALID}, 32'd1);
        chk("add_alu", {28'd0, EX_ALU_CTRL}, 32'h0);
        chk("add_srca", EX_SRC_A, 32'd5);
        chk("add_srcb", EX_SRC_B, 32'd7);
        chk("add_rd", {27'd0, EX_RD}, 32'd3);
        chk("add_we", {31'd0, EX_REG_WE}, 32'd1);
        chk("add_pc", EX_PC, 32'h40);
        chk("add_rs2val", EX_RS2_VAL, 32'd7);

        // SRAI x5,x6,3
        issue(32'h40335293, 32'h44, 32'd100, 32'd0);
        step();
        chk("srai_alu", {28'd0, EX_ALU_CTRL}, 32'hD);
        chk("srai_srcb", EX_SRC_B, 32'd3);
        chk("srai_srca", EX_SRC_A, 32'd100);
        chk("srai_ill", {31'd0, EX_ILLEGAL}, 32'd0);

        // SRAI with instr[29] set -> illegal funct7
        issue(32'h60335293, 32'h48, 32'd100, 32'd0);
        step();
        chk("badsh_ill", {31'd0, EX_ILLEGAL}, 32'd1);
        chk("badsh_we", {31'd0, EX_REG_WE}, 32'd0);
        chk("badsh_alu", {28'd0, EX_ALU_CTRL}, 32'd0);
        chk("badsh_valid", {31'd0, EX_VALID}, 32'd1);

        // ADDI x1,x0,-1
        issue(32'hFFF00093, 32'h4C, 32'd9, 32'd0);
        step();
        chk("addi_srcb", EX_SRC_B, 32'hFFFF_FFFF);
        chk("addi_srca", EX_SRC_A, 32'd0);

        // SW x2,-4(x1)
        issue(32'hFE20AE23, 32'h50, 32'd5, 32'd77);
        step();
        chk("sw_srcb", EX_SRC_B, 32'hFFFF_FFFC);
        chk("sw_we", {31'd0, EX_REG_WE}, 32'd0);
        chk("sw_rs2val", EX_RS2_VAL, 32'd77);

        // BLT x1,x2
        issue(32'h0020C063, 32'h54, 32'd1, 32'd2);
        step();
        chk("blt_br", {31'd0, EX_BR}, 32'd1);
        chk("blt_f3", {29'd0, EX_BR_F3}, 32'd4);
        chk("blt_alu", {28'd0, EX_ALU_CTRL}, 32'h2);

        // AUIPC x1,1 at PC 0x100
        issue(32'h00001097, 32'h100, 32'd0, 32'd0);
        step();
        chk("auipc_srca", EX_SRC_A, 32'h100);
        chk("auipc_srcb", EX_SRC_B, 32'h1000);

        // JAL x1,0
        issue(32'h000000EF, 32'h200, 32'd0, 32'd0);
        step();
        chk("jal_srcb", EX_SRC_B, 32'd4);
        chk("jal_we", {31'd0, EX_REG_WE}, 32'd1);

        // ADD x0,x1,x2 -> write suppressed
        issue(32'h00208033, 32'h204, 32'd5, 32'd7);
        step();
        chk("rdx0_we", {31'd0, EX_REG_WE}, 32'd0);

        // Unknown opcode
        issue(32'h0000007F, 32'h208, 32'd0, 32'd0);
        step();
        chk("badop_ill", {31'd0, EX_ILLEGAL}, 32'd1);

        // LUI x1,0x12345
        issue(32'h123450B7, 32'h20C, 32'd0, 32'd0);
        step();
        chk("lui_alu", {28'd0, EX_ALU_CTRL}, 32'h9);
        chk("lui_srca", EX_SRC_A, 32'h1234_5000);
        chk("lui_srcb", EX_SRC_B, 32'd0);

        // Backpressure: LUI held while ADD waits upstream
        issue(32'h002081B3, 32'h210, 32'd11, 32'd22);
        EX_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ifready", {31'd0, IF_READY}, 32'd0);
            step();
            chk("bp_srca", EX_SRC_A, 32'h1234_5000);
            chk("bp_alu", {28'd0, EX_ALU_CTRL}, 32'h9);
            chk("bp_valid", {31'd0, EX_VALID}, 32'd1);
        end
        EX_READY = 1'b1;
        #1;
        chk("bp_release_ifready", {31'd0, IF_READY}, 32'd1);
        step();
        chk("bp_next_srca", EX_SRC_A, 32'd11);
        chk("bp_next_srcb", EX_SRC_B, 32'd22);
        chk("bp_next_pc", EX_PC, 32'h210);

        // FLUSH with an accepted instruction
        issue(32'h002081B3, 32'h214, 32'd5, 32'd7);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk("flush_valid", {31'd0, EX_VALID}, 32'd0);

        // Reset in the middle of a stall
        issue(32'h002081B3, 32'h218, 32'd5, 32'd7);
        step();
        EX_READY = 1'b0;
        step();
        chk("stall_valid", {31'd0, EX_VALID}, 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_valid", {31'd0, EX_VALID}, 32'd0);
        chk("midrst_ifready", {31'd0, IF_READY}, 32'd1);
        chk("midrst_srca", EX_SRC_A, 32'd0);

        // Bypass from writeback on rs1
        issue(32'h002081B3, 32'h300, 32'd5, 32'd7);
        WB_WE = 1'b1; WB_RD = 5'd1; WB_DATA = 32'hDEAD_BEEF;
        step();
        chk("byp_srca", EX_SRC_A, 32'hDEAD_BEEF);
        chk("byp_srcb", EX_SRC_B, 32'd7);

        // Writeback to x0 never bypasses
        WB_RD = 5'd0;
        step();
        chk("byp_x0_srca", EX_SRC_A, 32'd5);
        WB_WE = 1'b0;

        // ADD x3,x0,x2: x0 reads zero regardless of regfile data
        issue(32'h002001B3, 32'h304, 32'hFFFF_FFFF, 32'd7);
        step();
        chk("x0_srca", EX_SRC_A, 32'd0);

        // Transfer with no new instruction empties the register
        IF_VALID = 1'b0;
        step();
        chk("drain_valid", {31'd0, EX_VALID}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the CARP RV32I core, sitting between fetch and the ALU in execute. It decodes a 32-bit instruction into the 4-bit ALU control code, selects and bypasses operands, and forms the immediate. Results are registered into a single ID/EX pipeline register under a valid/ready handshake, so the ALU sees stable operands and control for one cycle per instruction.

## Interface
- No parameters; XLEN fixed at 32.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- IF_VALID  in  1  fetch presents an instruction
- IF_READY  out  1  stage accepts an instruction this cycle
- IF_INSTR  in  32  instruction word
- IF_PC  in  32  PC of IF_INSTR
- RS1_ADDR, RS2_ADDR  out  5 each  register-file read addresses, combinational from IF_INSTR[19:15] and IF_INSTR[24:20]
- RS1_DATA, RS2_DATA  in  32 each  register-file read data, same cycle
- WB_WE, WB_RD, WB_DATA  in  1/5/32  writeback port, used for bypass
- FLUSH  in  1  kill the registered and incoming instruction
- EX_VALID  out  1  ID/EX register holds an instruction
- EX_READY  in  1  execute consumes it
- EX_ALU_CTRL  out  4  ALU operation code
- EX_SRC_A, EX_SRC_B  out  32 each  ALU operands
- EX_RS2_VAL  out  32  store data, bypassed rs2
- EX_RD  out  5; EX_REG_WE  out  1; EX_PC  out  32
- EX_BR  out  1  conditional branch; EX_BR_F3  out  3  branch funct3
- EX_ILLEGAL  out  1  undecodable instruction

## Operation
- ALU codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, COPY_A/LUI 1001, SRA 1101.
- OP (0110011): code = {instr[30], funct3}.
  - funct7 must be 0000000, or 0100000 with funct3 000 or 101; anything else is illegal.
  - SRC_A = rs1, SRC_B = rs2.
- OP-IMM (0010011): code = {0, funct3}, except funct3 101 with instr[30]=1, which gives 1101.
  - SLLI needs imm[11:5]=0; SRLI/SRAI need imm[11:5] = 0000000 or 0100000; otherwise illegal.
  - SRC_B = sign-extended I-immediate.
- LUI: code 1001, SRC_A = {instr[31:12], 12'b0}, SRC_B = 0.
- AUIPC: ADD, SRC_A = PC, SRC_B = U-immediate.
- LOAD: ADD, SRC_A = rs1, SRC_B = I-immediate.
- STORE: ADD, SRC_A = rs1, SRC_B = S-immediate, REG_WE = 0.
- JAL/JALR: ADD, SRC_A = PC, SRC_B = 4, REG_WE = 1.
- BRANCH: EX_BR = 1, REG_WE = 0, SRC_A/SRC_B = rs1/rs2.
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - funct3 010 or 011 is illegal.
- Unknown opcode or any illegal case: EX_ILLEGAL = 1, code 0000, REG_WE = 0, EX_BR = 0. The instruction still propagates with EX_VALID = 1.
- REG_WE is forced to 0 when rd = x0.
- Operand read: register x0 always reads 0, regardless of RS*_DATA.
- Bypass: if WB_WE = 1, WB_RD ≠ 0 and WB_RD equals the source register, use WB_DATA instead of RS*_DATA. Bypass takes priority over register-file data.
- Load-use and ALU-ALU hazards are not detected here; the hazard unit stalls via EX_READY / IF_VALID.

## Timing
- Latency 1 cycle: an accepted instruction appears on the EX_* outputs after the next rising edge.
- Handshake:
  - IF_READY = !EX_VALID || EX_READY (combinational).
  - Accept when IF_VALID && IF_READY.
  - Transfer to execute when EX_VALID && EX_READY.
- Hold: while EX_VALID && !EX_READY, all EX_* outputs stay bit-stable.
- Register update when !FLUSH:
  - On accept, EX_VALID = 1 and the payload is loaded.
  - On transfer with no accept, EX_VALID = 0 and the payload is don't-care but held.
- FLUSH (priority over all else): next cycle EX_VALID = 0. The incoming instruction is dropped even if IF_VALID = 1. IF_READY is unaffected.
- Reset: all EX_* outputs are 0 (EX_VALID = 0, EX_ALU_CTRL = 0000). Reset has priority over FLUSH and accept. IF_READY = 1 the cycle after reset.
- Two-state control (EMPTY/FULL, encoded by EX_VALID):
  - EMPTY → FULL on accept.
  - FULL → EMPTY on transfer without accept, or on FLUSH.
  - FULL → FULL on simultaneous transfer and accept.

## Structure
- carp_pkg holds:
  - alu_ctrl_e enum with the 4-bit codes above, shared with the ALU.
  - opcode_e localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR).
- Sub-module imm_gen: combinational; takes instr[31:0] and an immediate-type select, returns the sign-extended 32-bit I/S/B/U/J immediate.
- Decode logic is one always_comb; the ID/EX register is one always_ff.

## Test plan
- ADD x3,x1,x2 (0x002081B3), RS1_DATA = 5, RS2_DATA = 7 → next cycle EX_VALID = 1, ALU_CTRL = 0000, SRC_A = 5, SRC_B = 7, RD = 3, REG_WE = 1.
- SRAI x5,x6,3 (0x40335293) → ALU_CTRL = 1101, SRC_B = 3.
- Same encoding with instr[29] set → EX_ILLEGAL = 1, REG_WE = 0.
- LUI x1,0x12345 (0x123450B7) → ALU_CTRL = 1001, SRC_A = 0x12345000.
- Backpressure: EX full with EX_READY = 0 for 3 cycles while IF_VALID = 1 → IF_READY = 0 and outputs unchanged.
  - Then raise EX_READY → the pending instruction is accepted, and is visible in the following cycle.
- FLUSH asserted together with an accepted IF_VALID → next cycle EX_VALID = 0. Reset asserted mid-stall → EX_VALID = 0, IF_READY = 1.
- Bypass: WB_WE = 1, WB_RD = 1, WB_DATA = 0xDEADBEEF during ADD x3,x1,x2 → SRC_A = 0xDEADBEEF.
  - Same with WB_RD = 0 → SRC_A = RS1_DATA.
  - ADD x3,x0,x2 with RS1_DATA = 0xFFFFFFFF → SRC_A = 0.
